// File: rtl/mio_bus_arbiter.sv
// Two-port arbiter sharing one fixed-latency synchronous memory/IO port between
// the CPU controller (port C) and the DMA/VGA-fetch engine (port D).
//
// state  | meaning
// IDLE   | arbitrate; latch the winner's addr/we/wdata into the mem_* registers
// ACCESS | single-cycle mem_en strobe; load the latency counter
// WAIT   | MEM_LAT cycles; read data captured when the counter reaches 1
// RESP   | one-cycle ready pulse to the winner
module mio_bus_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MEM_LAT  = 2,
    parameter int CPU_PRIO = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    grant,
    output logic [1:0]    state_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_WAIT   = 2'b10,
        S_RESP   = 2'b11
    } state_t;

    localparam logic [3:0] LP_LAT = 4'(MEM_LAT);

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic          r_last_d;
    logic [1:0]    r_grant;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_c_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          w_pick_c;
    logic          w_pick_d;

    // On a tie, C wins under CPU priority or when D was the last owner.
    always_comb begin
        w_pick_c = 1'b0;
        w_pick_d = 1'b0;
        if (c_req && d_req) begin
            if ((CPU_PRIO != 0) || r_last_d) begin
                w_pick_c = 1'b1;
            end else begin
                w_pick_d = 1'b1;
            end
        end else if (c_req) begin
            w_pick_c = 1'b1;
        end else if (d_req) begin
            w_pick_d = 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_pick_c || w_pick_d) w_next = S_ACCESS;
            S_ACCESS: w_next = S_WAIT;
            S_WAIT:   if (r_cnt == 4'd1) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_last_d    <= 1'b1;
            r_grant     <= 2'b00;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_c_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_c) begin
                        r_mem_we    <= c_we;
                        r_mem_addr  <= c_addr;
                        r_mem_wdata <= c_wdata;
                        r_grant     <= 2'b01;
                        r_last_d    <= 1'b0;
                    end else if (w_pick_d) begin
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_grant     <= 2'b10;
                        r_last_d    <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    r_cnt <= LP_LAT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if ((r_cnt == 4'd1) && !r_mem_we) begin
                        if (r_grant[0]) begin
                            r_c_rdata <= mem_rdata;
                        end else if (r_grant[1]) begin
                            r_d_rdata <= mem_rdata;
                        end
                    end
                end
                S_RESP: begin
                    r_grant <= 2'b00;
                end
                default: begin
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    assign mem_en    = (r_state == S_ACCESS);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign c_rdata   = r_c_rdata;
    assign d_rdata   = r_d_rdata;
    assign c_ready   = (r_state == S_RESP) && r_grant[0];
    assign d_ready   = (r_state == S_RESP) && r_grant[1];
    assign grant     = r_grant;
    assign state_out = r_state;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed bench for mio_bus_arbiter: four builds share the stimulus;
// idx0 MEM_LAT=2 round-robin, idx1 MEM_LAT=2 CPU priority, idx2 MEM_LAT=1, idx3 MEM_LAT=15.
module tb_mio_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;

    logic [31:0] c_rdata_o [4];
    logic [31:0] d_rdata_o [4];
    logic [31:0] mem_addr_o [4];
    logic [31:0] mem_wdata_o [4];
    logic        c_ready_o [4];
    logic        d_ready_o [4];
    logic        mem_en_o [4];
    logic        mem_we_o [4];
    logic [1:0]  grant_o [4];
    logic [1:0]  state_o [4];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mio_bus_arbiter #(
            .AW(32), .DW(32),
            .MEM_LAT((g == 3) ? 15 : (g == 2) ? 1 : 2),
            .CPU_PRIO((g == 1) ? 1 : 0)
        ) u_dut (
            .clk(clk), .reset_n(reset_n),
            .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
            .c_rdata(c_rdata_o[g]), .c_ready(c_ready_o[g]),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_rdata(d_rdata_o[g]), .d_ready(d_ready_o[g]),
            .mem_en(mem_en_o[g]), .mem_we(mem_we_o[g]),
            .mem_addr(mem_addr_o[g]), .mem_wdata(mem_wdata_o[g]),
            .mem_rdata(mem_rdata),
            .grant(grant_o[g]), .state_out(state_o[g])
        );
    end

    task automatic do_reset();
        reset_n = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({state_o[i], grant_o[i], mem_en_o[i], mem_we_o[i], c_ready_o[i], d_ready_o[i]} !== 8'h00) begin
                bad++;
                $display("FAIL reset_ctrl idx=%0d got=%h exp=00", i,
                         {state_o[i], grant_o[i], mem_en_o[i], mem_we_o[i], c_ready_o[i], d_ready_o[i]});
            end
            total++;
            if ({mem_addr_o[i], mem_wdata_o[i], c_rdata_o[i], d_rdata_o[i]} !== 128'h0) begin
                bad++;
                $display("FAIL reset_data idx=%0d got=%h exp=0", i,
                         {mem_addr_o[i], mem_wdata_o[i], c_rdata_o[i], d_rdata_o[i]});
            end
        end
        do_reset();
    endtask

    task automatic test_c_read();
        logic [1:0] st_exp;
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        for (int cyc = 0; cyc <= 6; cyc++) begin
            st_exp = (cyc == 1) ? 2'd1 : (cyc == 2 || cyc == 3) ? 2'd2 : (cyc == 4) ? 2'd3 : 2'd0;
            total++;
            if (state_o[0] !== st_exp) begin
                bad++; $display("FAIL cread_state cyc=%0d got=%0d exp=%0d", cyc, state_o[0], st_exp);
            end
            total++;
            if (mem_en_o[0] !== (cyc == 1)) begin
                bad++; $display("FAIL cread_mem_en cyc=%0d got=%b exp=%b", cyc, mem_en_o[0], cyc == 1);
            end
            total++;
            if (c_ready_o[0] !== (cyc == 4) || d_ready_o[0] !== 1'b0) begin
                bad++; $display("FAIL cread_ready cyc=%0d got c=%b d=%b exp c=%b d=0", cyc,
                                c_ready_o[0], d_ready_o[0], cyc == 4);
            end
            total++;
            if (c_rdata_o[0] !== ((cyc >= 4) ? 32'hDEADBEEF : 32'h0)) begin
                bad++; $display("FAIL cread_rdata cyc=%0d got=%h", cyc, c_rdata_o[0]);
            end
            if (cyc == 1) begin
                total++;
                if (mem_addr_o[0] !== 32'h10 || mem_we_o[0] !== 1'b0) begin
                    bad++; $display("FAIL cread_addr got=%h we=%b exp=00000010 we=0", mem_addr_o[0], mem_we_o[0]);
                end
            end
            mem_rdata = (cyc == 3) ? 32'hDEADBEEF : 32'hBAD0BAD0;
            if (cyc == 4) c_req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        int t, ph;
        logic [1:0] g_exp;
        logic [31:0] crd_exp;
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234;
        for (int cyc = 0; cyc <= 20; cyc++) begin
            t = cyc / 5; ph = cyc % 5;
            g_exp = (ph == 0) ? 2'b00 : (t % 2 == 0) ? 2'b01 : 2'b10;
            total++;
            if (grant_o[0] !== g_exp) begin
                bad++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", cyc, grant_o[0], g_exp);
            end
            total++;
            if (c_ready_o[0] !== (ph == 4 && t % 2 == 0) || d_ready_o[0] !== (ph == 4 && t % 2 == 1)) begin
                bad++; $display("FAIL rr_ready cyc=%0d got c=%b d=%b", cyc, c_ready_o[0], d_ready_o[0]);
            end
            total++;
            if (d_rdata_o[0] !== 32'h0) begin
                bad++; $display("FAIL rr_drdata cyc=%0d got=%h exp=0", cyc, d_rdata_o[0]);
            end
            crd_exp = (cyc >= 14) ? 32'hCAFE000D : (cyc >= 4) ? 32'hCAFE0003 : 32'h0;
            total++;
            if (c_rdata_o[0] !== crd_exp) begin
                bad++; $display("FAIL rr_crdata cyc=%0d got=%h exp=%h", cyc, c_rdata_o[0], crd_exp);
            end
            if (cyc == 6) begin
                total++;
                if (mem_en_o[0] !== 1'b1 || mem_we_o[0] !== 1'b1 || mem_addr_o[0] !== 32'h20 ||
                    mem_wdata_o[0] !== 32'h1234) begin
                    bad++; $display("FAIL rr_dwrite got en=%b we=%b addr=%h wdata=%h exp 1 1 20 1234",
                                    mem_en_o[0], mem_we_o[0], mem_addr_o[0], mem_wdata_o[0]);
                end
            end
            mem_rdata = 32'hCAFE0000 + 32'(cyc);
            if (cyc == 19) begin c_req = 1'b0; d_req = 1'b0; end
            @(negedge clk);
        end
    endtask

    task automatic test_cpu_prio();
        int t, ph;
        logic [1:0] g_exp;
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h88;
        for (int cyc = 0; cyc <= 20; cyc++) begin
            t = cyc / 5; ph = cyc % 5;
            g_exp = (ph == 0) ? 2'b00 : (t < 3) ? 2'b01 : 2'b10;
            total++;
            if (grant_o[1] !== g_exp) begin
                bad++; $display("FAIL prio_grant cyc=%0d got=%b exp=%b", cyc, grant_o[1], g_exp);
            end
            total++;
            if (c_ready_o[1] !== (ph == 4 && t < 3) || d_ready_o[1] !== (ph == 4 && t == 3)) begin
                bad++; $display("FAIL prio_ready cyc=%0d got c=%b d=%b", cyc, c_ready_o[1], d_ready_o[1]);
            end
            if (cyc == 14) c_req = 1'b0;
            if (cyc == 19) d_req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_latency(input int idx, input int lat);
        int n_en;
        logic [31:0] rd_exp;
        do_reset();
        n_en = 0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h30;
        for (int cyc = 0; cyc <= lat + 5; cyc++) begin
            if (mem_en_o[idx] === 1'b1) n_en++;
            total++;
            if (c_ready_o[idx] !== (cyc == lat + 2)) begin
                bad++; $display("FAIL lat%0d_ready cyc=%0d got=%b exp=%b", lat, cyc, c_ready_o[idx], cyc == lat + 2);
            end
            rd_exp = (cyc >= lat + 2) ? (32'h5A5A0000 + 32'(lat + 1)) : 32'h0;
            total++;
            if (c_rdata_o[idx] !== rd_exp) begin
                bad++; $display("FAIL lat%0d_rdata cyc=%0d got=%h exp=%h", lat, cyc, c_rdata_o[idx], rd_exp);
            end
            mem_rdata = 32'h5A5A0000 + 32'(cyc);
            if (cyc == lat + 2) c_req = 1'b0;
            @(negedge clk);
        end
        total++;
        if (n_en != 1) begin
            bad++; $display("FAIL lat%0d_en_pulses got=%0d exp=1", lat, n_en);
        end
    endtask

    task automatic test_drop_req();
        logic [1:0] st_exp;
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h80;
        for (int cyc = 0; cyc <= 8; cyc++) begin
            st_exp = (cyc == 1) ? 2'd1 : (cyc == 2 || cyc == 3) ? 2'd2 : (cyc == 4) ? 2'd3 : 2'd0;
            total++;
            if (state_o[0] !== st_exp || grant_o[0] !== ((cyc >= 1 && cyc <= 4) ? 2'b01 : 2'b00)) begin
                bad++; $display("FAIL drop_state cyc=%0d got st=%0d g=%b exp st=%0d", cyc, state_o[0], grant_o[0], st_exp);
            end
            total++;
            if (c_ready_o[0] !== (cyc == 4) || mem_en_o[0] !== (cyc == 1)) begin
                bad++; $display("FAIL drop_ready cyc=%0d got rdy=%b en=%b", cyc, c_ready_o[0], mem_en_o[0]);
            end
            if (cyc == 2) c_req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        repeat (2) @(negedge clk);
        total++;
        if (state_o[0] !== 2'd2) begin
            bad++; $display("FAIL rmid_pre got=%0d exp=2", state_o[0]);
        end
        reset_n = 1'b0;
        d_req = 1'b1;
        #1;
        total++;
        if (state_o[0] !== 2'd0 || mem_en_o[0] !== 1'b0 || grant_o[0] !== 2'b00 ||
            c_ready_o[0] !== 1'b0 || d_ready_o[0] !== 1'b0) begin
            bad++; $display("FAIL rmid_async got st=%0d en=%b g=%b cr=%b dr=%b exp 0 0 00 0 0",
                            state_o[0], mem_en_o[0], grant_o[0], c_ready_o[0], d_ready_o[0]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (grant_o[0] !== 2'b01) begin
            bad++; $display("FAIL rmid_tie got=%b exp=01", grant_o[0]);
        end
        reset_n = 1'b0;
        c_req = 1'b0;
        #1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (grant_o[0] !== 2'b10) begin
            bad++; $display("FAIL rmid_donly got=%b exp=10", grant_o[0]);
        end
        d_req = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_c_read();
        test_round_robin();
        test_cpu_prio();
        test_latency(2, 1);
        test_latency(3, 15);
        test_drop_req();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
